// File: rtl/ahb3_decode_pipe.sv
// AHB-Lite 1:N address decoder: combinational address-phase select, registered data-phase mux, zero added wait states.
// Stalls follow the selected slave's HREADYOUT; unmapped NONSEQ/SEQ accesses get a two-cycle ERROR from the default slave.
module ahb3_decode_pipe #(
  parameter int                      SLAVES    = 4,
  parameter int                      XLEN      = 32,
  parameter int                      PLEN      = 32,
  parameter logic [SLAVES*PLEN-1:0]  ADDR_BASE = '0,
  parameter logic [SLAVES*PLEN-1:0]  ADDR_MASK = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   m_hsel_i,
  input  logic [PLEN-1:0]        m_haddr_i,
  input  logic [XLEN-1:0]        m_hwdata_i,
  input  logic                   m_hwrite_i,
  input  logic [2:0]             m_hsize_i,
  input  logic [2:0]             m_hburst_i,
  input  logic [3:0]             m_hprot_i,
  input  logic [1:0]             m_htrans_i,
  input  logic                   m_hmastlock_i,
  output logic [XLEN-1:0]        m_hrdata_o,
  output logic                   m_hready_o,
  output logic                   m_hresp_o,
  output logic [SLAVES-1:0]      s_hsel_o,
  output logic [PLEN-1:0]        s_haddr_o,
  output logic [XLEN-1:0]        s_hwdata_o,
  output logic                   s_hwrite_o,
  output logic [2:0]             s_hsize_o,
  output logic [2:0]             s_hburst_o,
  output logic [3:0]             s_hprot_o,
  output logic [1:0]             s_htrans_o,
  output logic                   s_hmastlock_o,
  output logic                   s_hready_o,
  input  logic [SLAVES*XLEN-1:0] s_hrdata_i,
  input  logic [SLAVES-1:0]      s_hreadyout_i,
  input  logic [SLAVES-1:0]      s_hresp_i,
  output logic                   dec_err_o,
  output logic [PLEN-1:0]        dec_err_addr_o
);

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [SLAVES-1:0] hit;
  logic [SLAVES-1:0] dsel;
  logic              found;
  logic              err_req;
  logic [PLEN-1:0]   base;
  logic [PLEN-1:0]   mask;

  // Priority decode: lowest-indexed matching region wins, so hit is one-hot or zero.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    base  = '0;
    mask  = '0;
    for (int i = 0; i < SLAVES; i++) begin
      base = ADDR_BASE[i*PLEN +: PLEN];
      mask = ADDR_MASK[i*PLEN +: PLEN];
      if (!found && (mask != '0) && (((m_haddr_i ^ base) & mask) == '0)) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign err_req = m_hsel_i & ~(|hit) & m_htrans_i[1];

  assign s_hsel_o      = m_hsel_i ? hit : '0;
  assign s_haddr_o     = m_haddr_i;
  assign s_hwdata_o    = m_hwdata_i;
  assign s_hwrite_o    = m_hwrite_i;
  assign s_hsize_o     = m_hsize_i;
  assign s_hburst_o    = m_hburst_i;
  assign s_hprot_o     = m_hprot_i;
  assign s_htrans_o    = m_htrans_i;
  assign s_hmastlock_o = m_hmastlock_i;
  assign s_hready_o    = m_hready_o;
  assign dec_err_o     = (state == ST_ERR1);

  always_comb begin
    m_hrdata_o = '0;
    m_hready_o = 1'b1;
    m_hresp_o  = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (dsel[i]) begin
        m_hrdata_o = s_hrdata_i[i*XLEN +: XLEN];
        m_hready_o = s_hreadyout_i[i];
        m_hresp_o  = s_hresp_i[i];
      end
    end
    // The default slave owns the response while an error is in flight (dsel is zero then).
    case (state)
      ST_ERR1: begin
        m_hready_o = 1'b0;
        m_hresp_o  = 1'b1;
      end
      ST_ERR2: begin
        m_hready_o = 1'b1;
        m_hresp_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OK:   if (m_hready_o && err_req) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = err_req ? ST_ERR1 : ST_OK;
      default: state_nxt = ST_OK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_OK;
      dsel           <= '0;
      dec_err_addr_o <= '0;
    end else begin
      state <= state_nxt;
      if (m_hready_o) begin
        dsel <= m_hsel_i ? hit : '0;
        if (err_req) dec_err_addr_o <= m_haddr_i;
      end
    end
  end

endmodule

// File: doc/ahb3_decode_pipe.md
Name: ahb3_decode_pipe

Overview:
- Next-generation AHB-Lite address decoder for the SoC interconnect. One master port fans out to SLAVES slave ports.
- Address map comes from per-slave base/mask parameter vectors.
- Adds pipelined data-phase routing: response and read-data mux select is registered at the address phase. An internal default slave gives the two-cycle AHB ERROR response on unmapped accesses. The faulting address is captured for software.
- Sits between a master-side arbiter/bridge and the peripheral/memory slaves.

Parameters:
- SLAVES, 4, number of slave ports (1..16).
- XLEN, 32, data width in bits (multiple of 8).
- PLEN, 32, address width in bits.
- ADDR_BASE, {SLAVES{PLEN'h0}}, packed SLAVES*PLEN vector; slice i is the base of slave i.
- ADDR_MASK, {SLAVES{PLEN'h0}}, packed SLAVES*PLEN vector; slice i marks the compared bits of slave i. A mask of 0 disables slave i.

Ports:
- clk_i  in  1  bus clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_hsel_i  in  1  master select.
- m_haddr_i  in  PLEN  address.
- m_hwdata_i  in  XLEN  write data.
- m_hwrite_i  in  1  write.
- m_hsize_i  in  3  size.
- m_hburst_i  in  3  burst.
- m_hprot_i  in  4  protection.
- m_htrans_i  in  2  transfer type.
- m_hmastlock_i  in  1  locked.
- m_hrdata_o  out  XLEN  read data.
- m_hready_o  out  1  transfer done; also the slaves' HREADY input.
- m_hresp_o  out  1  error response.
- s_hsel_o  out  SLAVES  per-slave select.
- s_haddr_o  out  PLEN  broadcast.
- s_hwdata_o  out  XLEN  broadcast.
- s_hwrite_o  out  1  broadcast.
- s_hsize_o  out  3  broadcast.
- s_hburst_o  out  3  broadcast.
- s_hprot_o  out  4  broadcast.
- s_htrans_o  out  2  broadcast.
- s_hmastlock_o  out  1  broadcast.
- s_hready_o  out  1  copy of m_hready_o (slave HREADY input).
- s_hrdata_i  in  SLAVES*XLEN  packed per-slave read data.
- s_hreadyout_i  in  SLAVES  per-slave HREADYOUT.
- s_hresp_i  in  SLAVES  per-slave HRESP.
- dec_err_o  out  1  one-cycle pulse on each default-slave ERROR.
- dec_err_addr_o  out  PLEN  address of the last unmapped NONSEQ/SEQ access.

Behaviour:
- Match: match[i] = ((m_haddr_i ^ ADDR_BASE[i]) & ADDR_MASK[i]) == 0 && ADDR_MASK[i] != 0.
- Overlapping regions: lowest index wins. hit is one-hot or zero.
- s_hsel_o[i] = m_hsel_i & hit[i], combinational in the address phase. Broadcast outputs are direct wires.
- Data-phase register: when m_hready_o=1, the block latches
  - dsel <= m_hsel_i ? hit : 0
  - dflt <= m_hsel_i & ~|hit & m_htrans_i[1]
- When m_hready_o=0 the registers hold.
- Mux, when dsel has a bit set (slave i):
  - m_hrdata_o = s_hrdata_i[i]
  - m_hready_o = s_hreadyout_i[i]
  - m_hresp_o = s_hresp_i[i]
- Mux, when dsel=0 and no error in progress: m_hrdata_o=0, m_hready_o=1, m_hresp_o=0 (zero-wait OKAY; covers IDLE/BUSY and unselected transfers).
- Default-slave FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 when m_hready_o=1 && m_hsel_i && ~|hit && m_htrans_i in {NONSEQ, SEQ}. The address is captured into dec_err_addr_o at the same edge.
  - ERR1: m_hready_o=0, m_hresp_o=1, dec_err_o=1. Always -> ERR2.
  - ERR2: m_hready_o=1, m_hresp_o=1. The next address phase is sampled here: -> ERR1 if it is again unmapped NONSEQ/SEQ, else -> OK with dsel loaded normally.
  - A master that cancels to IDLE during ERR1 still receives the complete two-cycle response.
- Latency: 0 added wait states; the decoder has no combinational path from slave outputs back into decode.
- Reset (async assert, sync release):
  - dsel=0, FSM=OK, dec_err_addr_o=0.
  - Outputs: m_hready_o=1, m_hresp_o=0, m_hrdata_o=0, dec_err_o=0.
  - Reset mid-transfer (including during ERR1) aborts immediately to these values.
- Slave stall: while s_hreadyout_i[i]=0, dsel holds. A new address presented by the master is not latched until m_hready_o=1.

Test Plan:
- SLAVES=3, bases 0x0000_0000/0x4000_0000/0x8000_0000, masks 0xC000_0000. Read 0x4000_0010 -> s_hsel_o=3'b010 in the address phase; next cycle m_hrdata_o=s_hrdata_i[1]=0xDEAD_BEEF, m_hresp_o=0.
- Slave 0 holds s_hreadyout_i=0 for 3 cycles during a write to 0x10 -> m_hready_o low for 3 cycles. A back-to-back address to slave 2 is not routed until the 4th cycle; dsel switches only after.
- NONSEQ read to 0xC000_0004 (unmapped) -> ERR1 (hready=0, hresp=1, dec_err_o=1), then ERR2 (hready=1, hresp=1); dec_err_addr_o=0xC000_0004.
- IDLE transfer to 0xC000_0000 -> no error: hready=1, hresp=0, dec_err_o=0.
- Overlap: slave1 mask 0x0000_0000 (disabled), slave2 base 0x0 mask 0x8000_0000 -> access to 0x0000_0100 selects slave 0 only.
- Assert rst_ni=0 during ERR1 -> same cycle hready=1, hresp=0, dec_err_addr_o=0. After release, a read to slave 0 completes normally.
